// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data and full/empty flags.
// Flags are decoded from the registered occupancy count, so they always
// reflect the state committed at the most recent clock edge.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WREN,
  input  logic                  RDEN,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [ADDR_WIDTH:0]   CountFull = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CountOne  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Each request is gated only by the flag that guards it, so a full FIFO
  // still takes a read and an empty FIFO still takes a write.
  always_comb begin
    wr_acc = WREN && !full;
    rd_acc = RDEN && !empty;
  end

  // Next-state for pointers, occupancy and the read data register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array is deliberately left out of reset; stale entries are
  // unreachable once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Status flags and read data straight from registered state.
  always_comb begin
    full     = (count_q == CountFull);
    empty    = (count_q == '0);
    data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       WREN;
  logic       RDEN;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_dout;

  fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .WREN     (WREN),
    .RDEN     (RDEN),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare on the falling edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    bit wacc;
    bit racc;
    rst     = r;
    WREN    = w;
    RDEN    = rd;
    data_in = d;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_dout = 8'h00;
    end else begin
      wacc = w && (model_q.size() < 8);
      racc = rd && (model_q.size() > 0);
      if (racc) exp_dout = model_q.pop_front();
      if (wacc) model_q.push_back(d);
    end
    @(negedge clk);
    check("full",  32'(full),  32'(model_q.size() == 8));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("dout",  32'(data_out), 32'(exp_dout));
    check("dout_known", 32'($isunknown(data_out)), 32'd0);
  endtask

  initial begin
    exp_dout = 8'h00;
    rst = 1'b1; WREN = 1'b0; RDEN = 1'b0; data_in = 8'h00;
    @(negedge clk);

    // Reset held for two cycles, then idle.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill 1..10; the last two are dropped.
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 32'd1);

    // Drain ten times; data_out must stick at 8.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check("drain_last", 32'(data_out), 32'd8);
    check("drain_empty", 32'(empty), 32'd1);

    // Four entries stored, then six simultaneous read/writes of 11..16.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h21 + i));
    for (int i = 11; i <= 16; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
    check("simul_last", 32'(data_out), 32'd12);
    check("simul_count", 32'(model_q.size()), 32'd4);

    // Twenty write/read cycles to wrap both pointers more than twice.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Five entries stored, then reset with a write pending.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    check("rst_mid_dout", 32'(data_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("rst_mid_new", 32'(data_out), 32'h5A);
    check("rst_mid_empty", 32'(empty), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
